// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I load/store stage with a req/ack data-memory port; non-memory results pass through.
module mem_access_stage #(
  parameter int DMEM_TIMEOUT = 255,
  parameter int TMO_W = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        exc_misalign_o,
  output logic        exc_buserr_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, wdata_n, lane, ld_data;
  logic [3:0] be_q, be_n;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  logic we_q, rw_q, accept, is_mem, misal, timeout;
  logic [TMO_W-1:0] cnt;
  always_comb begin
    accept = state == IDLE && ex_valid_i;
    is_mem = mem_read_i | mem_write_i;
    misal = funct3_i[1] ? |alu_result_i[1:0] : funct3_i[0] & alu_result_i[0];
    be_n = funct3_i[1] ? 4'b1111 : (funct3_i[0] ? 4'b0011 : 4'b0001) << alu_result_i[1:0];
    wdata_n = funct3_i[1] ? rs2_data_i : funct3_i[0] ? {2{rs2_data_i[15:0]}} : {4{rs2_data_i[7:0]}};
    lane = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    ld_data = f3_q[1] ? dmem_rdata_i :
              f3_q[0] ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
    timeout = state == REQ && !dmem_ack_i && cnt == TMO_W'(DMEM_TIMEOUT - 1);
    state_n = state == IDLE ? (accept && is_mem && !misal ? REQ : IDLE) :
              state == REQ  ? (dmem_ack_i ? RESP : timeout ? IDLE : REQ) : IDLE;
  end
  assign ex_ready_o = state == IDLE;
  assign dmem_req_o = state == REQ;
  assign dmem_we_o = dmem_req_o & we_q;
  assign dmem_be_o = dmem_req_o ? be_q : 4'b0000;
  assign dmem_addr_o = {addr_q[31:2], 2'b00};
  assign dmem_wdata_o = wdata_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      f3_q <= '0;
      rd_q <= '0;
      we_q <= 1'b0;
      rw_q <= 1'b0;
      cnt <= '0;
      wb_valid_o <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_rd_addr_o <= '0;
      wb_data_o <= '0;
      exc_misalign_o <= 1'b0;
      exc_buserr_o <= 1'b0;
    end else begin
      state <= state_n;
      wb_valid_o <= 1'b0;
      exc_misalign_o <= 1'b0;
      exc_buserr_o <= 1'b0;
      if (accept) begin
        wb_valid_o <= !is_mem || misal;
        wb_reg_write_o <= !is_mem && reg_write_i && |rd_addr_i;
        wb_rd_addr_o <= rd_addr_i;
        wb_data_o <= alu_result_i;
        exc_misalign_o <= is_mem && misal;
        if (is_mem && !misal) begin
          addr_q <= alu_result_i;
          wdata_q <= wdata_n;
          be_q <= be_n;
          f3_q <= funct3_i;
          rd_q <= rd_addr_i;
          we_q <= mem_write_i;
          rw_q <= reg_write_i && |rd_addr_i;
          cnt <= '0;
        end
      end
      if (state == REQ) begin
        cnt <= cnt + 1'b1;
        if (dmem_ack_i || timeout) begin
          wb_valid_o <= 1'b1;
          wb_reg_write_o <= dmem_ack_i && !we_q && rw_q;
          wb_rd_addr_o <= rd_q;
          wb_data_o <= dmem_ack_i && !we_q ? ld_data : 32'b0;
          exc_buserr_o <= !dmem_ack_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized scoreboard bench with a byte-level memory reference model.
module tb_mem_access_stage;
  localparam int T = 4;
  logic clk_i = 0, reset_i = 1, ex_valid_i = 0, mem_read_i = 0, mem_write_i = 0, reg_write_i = 0;
  logic [31:0] alu_result_i = 0, rs2_data_i = 0, dmem_rdata_i = 0, dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [2:0] funct3_i = 0;
  logic [4:0] rd_addr_i = 0, wb_rd_addr_o;
  logic [3:0] dmem_be_o;
  logic ex_ready_o, dmem_req_o, dmem_we_o, dmem_ack_i, wb_valid_o, wb_reg_write_o, exc_misalign_o, exc_buserr_o;
  logic ack_r = 0, stray = 0;
  assign dmem_ack_i = ack_r | stray;
  mem_access_stage #(.DMEM_TIMEOUT(T), .TMO_W(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .funct3_i(funct3_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_data_o(wb_data_o), .exc_misalign_o(exc_misalign_o), .exc_buserr_o(exc_buserr_o));
  always #5 clk_i = ~clk_i;

  typedef struct packed {logic rw; logic [4:0] rd; logic [31:0] data; logic mis; logic berr;} exp_t;
  typedef struct packed {logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} req_t;
  exp_t exp_q[$];
  req_t req_q[$];
  int dly_q[$];
  logic [31:0] mem [0:255];
  logic [7:0] ref_b [0:1023];
  int n_cmp = 0, n_bad = 0;

  function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic int size_of(logic [2:0] f3);
    return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic [4:0] rd, input logic rw, input int dly);
    int n = 0, sz;
    exp_t e;
    req_t r;
    logic [31:0] v;
    @(negedge clk_i);
    ex_valid_i = 1; alu_result_i = a; rs2_data_i = d; funct3_i = f3;
    mem_read_i = mr; mem_write_i = mw; rd_addr_i = rd; reg_write_i = rw;
    while (!ex_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) check("accept_timeout", 0, 1);
    sz = size_of(f3);
    e = '{rw: 0, rd: rd, data: 0, mis: 0, berr: 0};
    if (!(mr || mw)) begin
      e.rw = rw && rd != 0; e.data = a;
    end else if (a % sz != 0) e.mis = 1;
    else begin
      r.addr = a & ~32'd3; r.we = mw;
      r.be = 4'(((1 << sz) - 1) << (a % 4));
      r.wdata = sz == 1 ? {4{d[7:0]}} : sz == 2 ? {2{d[15:0]}} : d;
      req_q.push_back(r); dly_q.push_back(dly);
      if (dly >= T) e.berr = 1;
      else if (mw) for (int i = 0; i < sz; i++) ref_b[a + i] = d[8*i +: 8];
      else begin
        v = 0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_b[a + i];
        if (!f3[2] && sz == 1 && v[7]) v = v | 32'hFFFF_FF00;
        if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        e.rw = rw && rd != 0; e.data = v;
      end
    end
    exp_q.push_back(e);
  endtask

  // memory responder: acks after the delay chosen for each request
  int busy = 0, k = 0, d = 0;
  req_t cap;
  always @(negedge clk_i) begin
    ack_r = 0;
    if (!dmem_req_o) busy = 0;
    else begin
      if (!busy) begin
        busy = 1; k = 0;
        if (req_q.size() == 0 || dly_q.size() == 0) begin
          check("unexpected_req", 1, 0); d = 1000;
        end else begin
          cap = req_q.pop_front(); d = dly_q.pop_front();
          check("req_addr", dmem_addr_o, cap.addr);
          check("req_be", {28'b0, dmem_be_o}, {28'b0, cap.be});
          check("req_we", {31'b0, dmem_we_o}, {31'b0, cap.we});
          if (cap.we) check("req_wdata", dmem_wdata_o, cap.wdata);
        end
      end else begin
        k++;
        check("req_stable", {dmem_addr_o[31:4], dmem_be_o}, {cap.addr[31:4], cap.be});
        check("ready_low", {31'b0, ex_ready_o}, 0);
      end
      if (k == d) begin
        ack_r = 1;
        dmem_rdata_i = mem[dmem_addr_o[9:2]];
        if (dmem_we_o) for (int i = 0; i < 4; i++)
          if (dmem_be_o[i]) mem[dmem_addr_o[9:2]][8*i +: 8] = dmem_wdata_o[8*i +: 8];
      end
    end
  end

  // monitor: every writeback pulse is matched against the scoreboard
  always @(negedge clk_i) begin
    exp_t e;
    if (wb_valid_o) begin
      if (exp_q.size() == 0) check("unexpected_wb", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wb_reg_write", {31'b0, wb_reg_write_o}, {31'b0, e.rw});
        check("wb_rd", {27'b0, wb_rd_addr_o}, {27'b0, e.rd});
        if (e.rw) check("wb_data", wb_data_o, e.data);
        check("exc_flags", {30'b0, exc_misalign_o, exc_buserr_o}, {30'b0, e.mis, e.berr});
      end
    end else if (exc_misalign_o || exc_buserr_o) check("exc_without_wb", 1, 0);
  end

  initial begin
    int op, sz;
    logic [31:0] a;
    logic [2:0] f3;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_b[4*i + j] = mem[i][8*j +: 8];
    end
    mem[128] = 32'h8001_7F00;
    for (int j = 0; j < 4; j++) ref_b[512 + j] = mem[128][8*j +: 8];
    repeat (3) @(negedge clk_i);
    check("rst_ready", {31'b0, ex_ready_o}, 1);
    check("rst_outs", {dmem_req_o, dmem_we_o, dmem_be_o, wb_valid_o, wb_reg_write_o, exc_misalign_o, exc_buserr_o}, 0);
    check("rst_wb_data", wb_data_o, 0);
    reset_i = 0;
    issue(32'h1234, 0, 0, 0, 0, 5, 1, 0);
    issue(32'hDEAD_BEEF, 0, 0, 0, 0, 9, 1, 0);
    issue(32'h55, 0, 0, 0, 0, 0, 1, 0);
    issue(32'h103, 32'hAABB_CCDD, 3'b000, 0, 1, 7, 1, 2);
    issue(32'h202, 0, 3'b001, 1, 0, 1, 1, 0);
    issue(32'h202, 0, 3'b101, 1, 0, 2, 1, 0);
    issue(32'h201, 0, 3'b000, 1, 0, 3, 1, 0);
    issue(32'h200, 0, 3'b111, 1, 0, 4, 1, 1);
    issue(32'h3, 0, 3'b010, 1, 0, 6, 1, 0);
    issue(32'h40, 0, 3'b010, 1, 0, 8, 1, 99);
    issue(32'h77, 0, 0, 0, 0, 10, 1, 0);
    issue(32'h100, 0, 3'b010, 1, 0, 11, 1, 3);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin @(negedge clk_i); ex_valid_i = 0; end
      op = $urandom_range(0, 3);
      f3 = 3'($urandom_range(0, 7));
      if (op >= 2) f3[2] = 0;
      sz = size_of(f3);
      a = op == 0 ? $urandom : $urandom_range(0, 1023);
      if (op != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      issue(a, $urandom, f3, op == 1 || op == 3, op >= 2, 5'($urandom), 1'($urandom), $urandom_range(0, 5));
    end
    issue(32'h40, 0, 3'b010, 1, 0, 12, 1, 100);
    @(negedge clk_i); ex_valid_i = 0;
    @(negedge clk_i);
    check("rmid_req", {31'b0, dmem_req_o}, 1);
    reset_i = 1;
    @(negedge clk_i);
    reset_i = 0;
    exp_q.delete(); req_q.delete(); dly_q.delete();
    check("rmid_req_drop", {31'b0, dmem_req_o}, 0);
    check("rmid_ready", {31'b0, ex_ready_o}, 1);
    check("rmid_no_wb", {31'b0, wb_valid_o}, 0);
    stray = 1;
    @(negedge clk_i);
    stray = 0;
    @(negedge clk_i);
    check("stray_ack_ready", {31'b0, ex_ready_o}, 1);
    check("stray_ack_req", {31'b0, dmem_req_o}, 0);
    issue(32'h99, 0, 0, 0, 0, 13, 1, 0);
    @(negedge clk_i); ex_valid_i = 0;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk_i);
    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of execute; consumes its ALU result, store data and control.
- Performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) against a req/ack data-memory port.
- Passes non-memory results through.
- Presents a registered result to writeback and back-pressures execute while a memory access is outstanding.

Parameters:
- DMEM_TIMEOUT, 255: max cycles to wait for dmem_ack_i before flagging a bus error.
- TMO_W, 8: width of the timeout counter; must hold DMEM_TIMEOUT.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- ex_valid_i  in  1  execute presents a valid instruction
- ex_ready_o  out  1  stage can accept this cycle
- alu_result_i  in  32  effective address, or result for non-memory ops
- rs2_data_i  in  32  store data
- funct3_i  in  3  RV32I width/sign code
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- rd_addr_i  in  5  destination register
- reg_write_i  in  1  instruction writes rd
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_ack_i  in  1  single-cycle acknowledge
- dmem_rdata_i  in  32  read word, valid with ack
- wb_valid_o  out  1  result valid to writeback, one-cycle pulse per instruction
- wb_reg_write_o  out  1  write enable for writeback
- wb_rd_addr_o  out  5  destination
- wb_data_o  out  32  write data
- exc_misalign_o  out  1  misaligned access pulse
- exc_buserr_o  out  1  timeout pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: state=IDLE; every output is 0 except ex_ready_o=1. Outstanding requests are dropped; a reset mid-access discards a late ack.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - ex_ready_o=1. Accept occurs when ex_valid_i is high.
  - No memory op: next cycle wb_valid_o=1, wb_data_o=alu_result_i, wb_reg_write_o=reg_write_i, wb_rd_addr_o=rd_addr_i. Latency 1, throughput 1/cycle.
  - Memory op, aligned: latch the address and control, go to REQ. Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Memory op, misaligned: no request is issued. Next cycle exc_misalign_o=1 and wb_valid_o=1 with wb_reg_write_o=0; stay IDLE.
  - mem_read_i and mem_write_i both high: treated as a store.
- REQ:
  - ex_ready_o=0. dmem_req_o=1, and dmem_addr_o, dmem_we_o, dmem_be_o and dmem_wdata_o are held stable until ack.
  - Timeout counter increments each cycle.
  - On dmem_ack_i: capture rdata, go to RESP. Ack in the first REQ cycle is legal.
  - Counter reaches DMEM_TIMEOUT without ack: drop req, pulse exc_buserr_o, emit wb_valid_o with wb_reg_write_o=0, return to IDLE.
- RESP:
  - ex_ready_o=0. wb_valid_o=1.
  - Load: wb_data_o = selected lane extended; wb_reg_write_o=reg_write_i.
  - Store: wb_reg_write_o=0.
  - Next state is IDLE.
  - Load latency (accept to wb_valid_o) = 2 + ack wait cycles.
- Byte enables and store data:
  - SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
  - Loads drive be of the accessed bytes.
- Load extension:
  - LB/LH: sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU: zero-extend.
  - funct3 011, 110, 111: treated as LW/SW.
- Register write suppression: rd_addr_i=0 forces wb_reg_write_o=0.

Test Plan:
- ALU pass-through: accept alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid_o=1, wb_data_o=0x1234, wb_rd_addr_o=5; back-to-back accepts every cycle.
- SB store: addr=0x103, rs2=0xAABBCCDD, ack after 3 cycles -> dmem_addr_o=0x100, be=4'b1000, wdata=0xDDDDDDDD; req held 3 cycles; ex_ready_o low until return to IDLE; wb_reg_write_o=0.
- Load extension: addr=0x202, rdata=0x8001_7F00 on immediate ack.
  - LH -> wb_data_o=0xFFFF_8001.
  - LHU -> 0x0000_8001.
  - LB at 0x201 -> 0x0000_007F.
- Misaligned load: LW at addr=0x3 -> no dmem_req_o, exc_misalign_o pulses once, wb_reg_write_o=0.
- Timeout: DMEM_TIMEOUT=4, LW with no ack -> exc_buserr_o pulses after 4 REQ cycles, req drops, stage returns to IDLE and accepts a new instruction.
- Reset mid-access: assert reset_i during REQ -> next cycle dmem_req_o=0, ex_ready_o=1, no wb_valid_o; an ack arriving afterwards is ignored.
